norm_clz32: RTL
===============

NORM_CLZ32 -- requirements
Module: norm_clz32

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, count fixed at 6 bits.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clock  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request; sampled only when ready=1.
REQ-006 a  input  32  operand to normalize.
REQ-007 mode  input  1  0 = count leading zeros (fill bit 0); 1 = count leading ones (fill bit 1).
REQ-008 ready  output  1  high in IDLE and DONE; a request can be accepted.
REQ-009 busy  output  1  high while in SCAN.
REQ-010 done  output  1  single-cycle pulse; count, d and zero are valid.
REQ-011 count  output  6  number of leading fill bits, range 0..32.
REQ-012 d  output  32  operand shifted left by count (bits past bit 31 dropped).
REQ-013 zero  output  1  operand consisted entirely of fill bits (count = 32).

Function
REQ-014 FSM states are IDLE, SCAN and DONE.
- IDLE -> SCAN on start=1.
- SCAN stays for exactly 5 edges, then -> DONE.
- DONE -> SCAN if start=1, else -> IDLE.
REQ-015 Accept on a rising edge with start=1 and ready=1.
- a and mode are latched into temp and fill.
- count accumulator is cleared; stage index is set to 4.
REQ-016 Each SCAN edge processes stage k (k = 4,3,2,1,0, i.e. widths 16,8,4,2,1).
- If temp[31:32-2^k] all equal fill: temp <= temp << 2^k (zero-filled); count += 2^k.
- Otherwise temp and count are held.
REQ-017 On the fifth SCAN edge, after the stage-0 step, the final count is corrected.
- If resulting temp[31] equals fill, count = 32, zero = 1 and d = 0.
- Otherwise zero = 0.
REQ-018 Latency is fixed: start high in cycle N gives done=1 in cycle N+6, for exactly one cycle.
REQ-019 Throughput: a start held high in the DONE cycle is accepted, giving one result per 6 cycles.
REQ-020 start while busy=1 is ignored; no queuing, and the in-flight result is unaffected.
REQ-021 count, d and zero update only at the transition into DONE, and hold until the next DONE transition or reset.
REQ-022 Changes to a or mode after accept have no effect on the in-flight result.
REQ-023 busy, ready and done are mutually consistent:
- busy=1 implies ready=0 and done=0.
- done=1 implies ready=1.

Reset
REQ-024 reset=1 on an edge forces state to IDLE and sets all outputs to their reset values, irrespective of state.
- Outputs: count=0, d=0, zero=0, done=0, busy=0, ready=1.
REQ-025 reset asserted mid-SCAN aborts the operation with no done pulse; start is acceptable on the first edge after reset deasserts.
REQ-026 reset has priority over start in the same cycle.

Configuration
REQ-027 Macro NORM_CLO_EN.
- Defined: mode is honoured per REQ-007.
- Undefined: mode is ignored, fill is always 0 (CLZ only), and the port remains present.

Verification
REQ-028 Start in cycle N with a=0x00010000, mode=0 -> done in cycle N+6 only; count=15, d=0x80000000, zero=0.
REQ-029 a=0x00000000, mode=0 -> count=32, d=0x00000000, zero=1; a=0x80000000, mode=0 -> count=0, d=0x80000000.
REQ-030 NORM_CLO_EN defined, a=0xFFF01234, mode=1 -> count=12, d=0x01234000.
- Same stimulus with the macro undefined -> count=0, d=0xFFF01234.
REQ-031 Assert reset in cycle N+3 of an operation -> no done pulse, outputs at reset values, ready=1.
- A start at N+2 with a different a is ignored.
REQ-032 Back-to-back starts held high with a=0x00000001 then a=0x0000FFFF:
- First done in cycle N+6, second in cycle N+12.
- count=31 then count=16.

Source files
------------

// File: rtl/norm_clz32_if.sv
// Request/result bundle for the norm_clz32 leading-fill normalizer.
// The master drives the operand and request; the slave (the normalizer) returns
// handshake status and the registered result.
interface norm_clz32_if;
   logic        start;
   logic [31:0] a;
   logic        mode;
   logic        ready;
   logic        busy;
   logic        done;
   logic [5:0]  count;
   logic [31:0] d;
   logic        zero;

   modport master (
      output start, a, mode,
      input  ready, busy, done, count, d, zero
   );

   modport slave (
      input  start, a, mode,
      output ready, busy, done, count, d, zero
   );
endinterface

// File: rtl/norm_clz32.sv
// norm_clz32: multi-cycle leading-fill counter and normalizer for a 32-bit operand.
// A binary search over five SCAN cycles (widths 16,8,4,2,1) strips leading fill
// bits, producing the count, the left-normalized operand and an all-fill flag.
// Build option: define NORM_CLO_EN to honour mode (count leading ones when mode=1);
// without it the block is CLZ-only and mode is ignored.
module norm_clz32 (
   input  logic         clock,
   input  logic         reset,
   norm_clz32_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e      state_q, state_d;

   logic [31:0] temp_q;
   logic        fill_q;
   logic [5:0]  acc_q;
   logic [2:0]  stage_q;

   logic [5:0]  count_q;
   logic [31:0] d_q;
   logic        zero_q;

   logic        ready;
   logic        busy;
   logic        done;
   logic        accept;
   logic        fill_in;

   logic [31:0] eq;
   logic        stage_hit;
   logic [31:0] temp_shift;
   logic [5:0]  step;
   logic [31:0] temp_next;
   logic [5:0]  acc_next;
   logic        all_fill;

`ifdef NORM_CLO_EN
   assign fill_in = bus.mode;
`else
   // mode stays on the port, but a CLZ-only build always fills with 0
   assign fill_in = bus.mode & 1'b0;
`endif

   assign accept = bus.start & ready;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (bus.start) state_d = StScan;
         end
         StScan: begin
            if (stage_q == 3'd0) state_d = StDone;
         end
         StDone: begin
            state_d = bus.start ? StScan : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_q)
         StIdle: ready = 1'b1;
         StScan: busy  = 1'b1;
         StDone: begin
            ready = 1'b1;
            done  = 1'b1;
         end
         default: ready = 1'b0;
      endcase
   end

   // One binary-search step: test the top 2^stage bits against the fill bit
   always_comb begin
      eq         = ~(temp_q ^ {32{fill_q}});
      stage_hit  = 1'b0;
      temp_shift = temp_q;
      step       = 6'd0;
      case (stage_q)
         3'd4: begin
            stage_hit  = &eq[31:16];
            temp_shift = temp_q << 16;
            step       = 6'd16;
         end
         3'd3: begin
            stage_hit  = &eq[31:24];
            temp_shift = temp_q << 8;
            step       = 6'd8;
         end
         3'd2: begin
            stage_hit  = &eq[31:28];
            temp_shift = temp_q << 4;
            step       = 6'd4;
         end
         3'd1: begin
            stage_hit  = &eq[31:30];
            temp_shift = temp_q << 2;
            step       = 6'd2;
         end
         3'd0: begin
            stage_hit  = eq[31];
            temp_shift = temp_q << 1;
            step       = 6'd1;
         end
         default: begin
            stage_hit  = 1'b0;
            temp_shift = temp_q;
            step       = 6'd0;
         end
      endcase
      temp_next = stage_hit ? temp_shift : temp_q;
      acc_next  = stage_hit ? (acc_q + step) : acc_q;
      // After the last step only an all-fill operand still has fill in bit 31
      all_fill  = (temp_next[31] == fill_q);
   end

   // Operand capture, search datapath and result registers
   always_ff @(posedge clock) begin
      if (reset) begin
         temp_q  <= 32'd0;
         fill_q  <= 1'b0;
         acc_q   <= 6'd0;
         stage_q <= 3'd0;
         count_q <= 6'd0;
         d_q     <= 32'd0;
         zero_q  <= 1'b0;
      end else if (accept) begin
         temp_q  <= bus.a;
         fill_q  <= fill_in;
         acc_q   <= 6'd0;
         stage_q <= 3'd4;
      end else if (state_q == StScan) begin
         temp_q <= temp_next;
         acc_q  <= acc_next;
         if (stage_q != 3'd0) begin
            stage_q <= stage_q - 3'd1;
         end else begin
            count_q <= all_fill ? 6'd32 : acc_next;
            d_q     <= all_fill ? 32'd0 : temp_next;
            zero_q  <= all_fill;
         end
      end
   end

   assign bus.ready = ready;
   assign bus.busy  = busy;
   assign bus.done  = done;
   assign bus.count = count_q;
   assign bus.d     = d_q;
   assign bus.zero  = zero_q;

endmodule
